// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides
// Optional subtract mode is enabled by defining CSA_SUB_EN.
module chunk_serial_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] resul,
   output logic             carry,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cy_q, cy_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] resul_q, resul_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] b_in;
   logic             cy_in;

`ifdef CSA_SUB_EN
   // Subtraction is A + ~B + 1; ci is ignored when subtracting.
   assign b_in  = sub ? ~r2 : r2;
   assign cy_in = sub ? 1'b1 : ci;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_in       = r2;
   assign cy_in      = ci;
`endif

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_cin;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      idx_d   = idx_q;
      resul_d = resul_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;

      a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
      // Carry into the MSB recovered from the sum bit, only meaningful on the last chunk.
      msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = r1;
               b_d     = b_in;
               cy_d    = cy_in;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            resul_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            cy_d = chunk_sum[CHUNK];
            if (idx_q == LAST_IDX) begin
               carry_d = chunk_sum[CHUNK];
               ovf_d   = msb_cin ^ chunk_sum[CHUNK];
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cy_q    <= 1'b0;
         idx_q   <= '0;
         resul_q <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         idx_q   <= idx_d;
         resul_q <= resul_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign resul     = resul_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - directed self-checking bench for chunk_serial_adder (WIDTH=32, CHUNK=8)
module tb_chunk_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] r1;
   logic [31:0] r2;
   logic        ci;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] resul;
   logic        carry;
   logic        ovf;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r1        (r1),
      .r2        (r2),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .resul     (resul),
      .carry     (carry),
      .ovf       (ovf)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Presents one operand set for a single edge, then scrambles the inputs.
   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
      int waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
      end
      r1 = a; r2 = b; ci = c; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; r1 = 32'hDEADBEEF; r2 = 32'hA5A5A5A5; ci = ~c; sub = ~s;
   endtask

   task automatic wait_result(output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      r1 = '0; r2 = '0; ci = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      tests_run++;
      if (resul !== 32'h0 || carry !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_out: resul=%h carry=%b ovf=%b want 00000000 0 0", resul, carry, ovf);
      end
   endtask

   task automatic test_wrap();
      int lat;
      accept(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      wait_result(lat);
      tests_run++;
      if (lat !== 4) begin
         tests_failed++;
         $display("FAIL wrap_latency: got %0d cycles want 4", lat);
      end
      tests_run++;
      if (resul !== 32'h00000000 || carry !== 1'b1 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_result: resul=%h carry=%b ovf=%b want 00000000 1 0", resul, carry, ovf);
      end
      handoff();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_handoff: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_overflow();
      int lat;
      accept(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      wait_result(lat);
      tests_run++;
      if (lat !== 4 || resul !== 32'h80000000 || carry !== 1'b0 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow: lat=%0d resul=%h carry=%b ovf=%b want 4 80000000 0 1", lat, resul, carry, ovf);
      end
      handoff();
   endtask

   task automatic test_chunk_carry();
      int lat;
      accept(32'h000000FF, 32'h00000000, 1'b1, 1'b0);
      wait_result(lat);
      tests_run++;
      if (lat !== 4 || resul !== 32'h00000100 || carry !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL chunk_carry: lat=%0d resul=%h carry=%b ovf=%b want 4 00000100 0 0", lat, resul, carry, ovf);
      end
      handoff();
   endtask

   task automatic test_stall();
      int lat;
      accept(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      wait_result(lat);
      tests_run++;
      if (resul !== 32'h23456789 || carry !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_result: resul=%h carry=%b ovf=%b want 23456789 0 0", resul, carry, ovf);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; r1 = 32'h00000001; r2 = 32'h00000001; ci = 1'b0;
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || resul !== 32'h23456789) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b resul=%h want 1 0 23456789",
                     i, out_valid, in_ready, resul);
         end
      end
      in_valid = 1'b0;
      handoff();
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || resul !== 32'h23456789) begin
         tests_failed++;
         $display("FAIL stall_idle_hold: out_valid=%b in_ready=%b resul=%h want 0 1 23456789",
                  out_valid, in_ready, resul);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      accept(32'h11111111, 32'h22222222, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || resul !== 32'h0 || carry !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b resul=%h carry=%b want 1 0 00000000 0",
                  in_ready, out_valid, resul, carry);
      end
      accept(32'h00000003, 32'h00000004, 1'b1, 1'b0);
      wait_result(lat);
      tests_run++;
      if (lat !== 4 || resul !== 32'h00000008 || carry !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_recover: lat=%0d resul=%h carry=%b want 4 00000008 0", lat, resul, carry);
      end
      handoff();
   endtask

   task automatic test_sub();
      int lat;
      logic [31:0] exp_res;
`ifdef CSA_SUB_EN
      exp_res = 32'hFFFFFFFE;
`else
      exp_res = 32'h0000000C;
`endif
      accept(32'h00000005, 32'h00000007, 1'b0, 1'b1);
      wait_result(lat);
      tests_run++;
      if (resul !== exp_res || carry !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL sub: resul=%h carry=%b ovf=%b want %h 0 0", resul, carry, ovf, exp_res);
      end
      handoff();
   endtask

   task automatic test_back_to_back();
      int first_rdy = -1;
      int second_rdy = -1;
      int done_cnt = 0;
      r1 = 32'h01020304; r2 = 32'h10203040; ci = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (in_ready === 1'b1) begin
            if (first_rdy < 0) first_rdy = i;
            else if (second_rdy < 0) second_rdy = i;
         end
         if (out_valid === 1'b1) begin
            done_cnt++;
            tests_run++;
            if (resul !== 32'h11223344 || in_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_result[%0d]: resul=%h in_ready=%b want 11223344 0", i, resul, in_ready);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests_run++;
      if (first_rdy !== 0 || second_rdy !== 6) begin
         tests_failed++;
         $display("FAIL b2b_period: accepts at %0d,%0d want 0,6", first_rdy, second_rdy);
      end
      tests_run++;
      if (done_cnt !== 3) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d results want 3", done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_overflow();
      test_chunk_carry();
      test_stall();
      test_reset_mid();
      test_sub();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
